// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit for the EX stage of a five-stage MIPS
//   pipeline. It executes MULT, MULTU, DIV and DIVU and holds the
//   architectural HI/LO registers.
//
//   Each operation takes WIDTH CALC cycles, one bit per cycle, then one FIX
//   cycle for sign correction and the HI/LO commit, then one DONE cycle.
//   done is high in the cycle WIDTH+2 cycles after the cycle in which start
//   was presented. busy covers CALC, FIX and DONE, so hazard logic can stall
//   MFHI/MFLO.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request a new op (accepted only in IDLE, and not with flush)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   srca         rs operand: multiplicand / dividend
//   srcb         rt operand: multiplier / divisor
//   flush        abort an op in CALC or FIX; drops a start in IDLE
//   whi, wlo     MTHI / MTLO write strobes (honoured only in IDLE)
//   wdata        MTHI / MTLO data
//   busy         high in CALC, FIX and DONE
//   done         one-cycle pulse; HI/LO already hold the new result
//   div_by_zero  high with done when a DIV/DIVU had srcb == 0
//   hi, lo       HI / LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   input  logic             whi,
   input  logic             wlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   state_t                 state_reg, state_next;
   logic [CW-1:0]          cnt_reg;

   // Operation context captured at start.
   logic                   is_div_reg;
   logic                   neg_q_reg;    // operand signs differ (product / quotient negated)
   logic                   neg_r_reg;    // dividend negative (remainder negated)
   logic                   dz_reg;       // divide with srcb == 0
   logic [WIDTH-1:0]       araw_reg;     // raw srca, returned in HI on divide-by-zero

   // Datapath. Multiply: acc += mcand when mplier[0]; mcand <<= 1; mplier >>= 1.
   // Divide: mplier_reg holds the dividend, shifted out MSB-first while the
   // quotient bits shift in at the bottom; mcand_reg[WIDTH-1:0] holds the divisor.
   logic [2*WIDTH-1:0]     acc_reg;
   logic [2*WIDTH-1:0]     mcand_reg;
   logic [WIDTH-1:0]       mplier_reg;
   logic [WIDTH-1:0]       rem_reg;

   logic [WIDTH-1:0]       hi_reg, lo_reg;

   // Start-time operand conditioning (sign-magnitude for the signed ops).
   logic                   op_signed;
   logic                   sign_a, sign_b;
   logic [WIDTH-1:0]       mag_a, mag_b;

   // One restoring-divide step.
   logic [WIDTH:0]         div_shift;
   logic [WIDTH:0]         div_diff;
   logic                   div_ok;

   // Sign-corrected results committed at the end of FIX.
   logic [2*WIDTH-1:0]     prod_fix;
   logic [WIDTH-1:0]       quo_fix, rem_fix;
   logic [WIDTH-1:0]       res_hi, res_lo;

   // -----------------------------------------------------------------------
   // Operand conditioning
   // -----------------------------------------------------------------------
   always_comb begin
      op_signed = ~op[0];
      sign_a    = op_signed & srca[WIDTH-1];
      sign_b    = op_signed & srcb[WIDTH-1];
      mag_a     = sign_a ? (~srca + 1'b1) : srca;
      mag_b     = sign_b ? (~srcb + 1'b1) : srcb;
   end

   // -----------------------------------------------------------------------
   // Divide step: shift the next dividend bit into the partial remainder and
   // try to subtract the divisor. The WIDTH+1 bit difference carries the
   // borrow, so no bit is lost even when the partial remainder's MSB is set.
   // -----------------------------------------------------------------------
   always_comb begin
      div_shift = {rem_reg, mplier_reg[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mcand_reg[WIDTH-1:0]};
      div_ok    = ~div_diff[WIDTH];
   end

   // -----------------------------------------------------------------------
   // Result fix-up. The most negative dividend over -1 needs no special case:
   // its magnitude 2^(WIDTH-1) divides to 2^(WIDTH-1), and negating that in
   // WIDTH bits returns the same pattern with a zero remainder.
   // -----------------------------------------------------------------------
   always_comb begin
      prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
      quo_fix  = neg_q_reg ? (~mplier_reg + 1'b1) : mplier_reg;
      rem_fix  = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (is_div_reg) begin
         if (dz_reg) begin
            res_hi = araw_reg;
            res_lo = {WIDTH{1'b1}};
         end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
      end
   end

   // -----------------------------------------------------------------------
   // FSM next state
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start && !flush) state_next = CALC;
         CALC: begin
            if (flush)                     state_next = IDLE;
            else if (cnt_reg == CNT_LAST)  state_next = FIX;
         end
         FIX:  state_next = flush ? IDLE : DONE;
         DONE: state_next = IDLE;      // flush ignored: result already committed
         default: state_next = IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // State, datapath and HI/LO registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         is_div_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         araw_reg   <= '0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         rem_reg    <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               // MTHI/MTLO land now even when an op starts in the same cycle;
               // the op's result overwrites both registers at the end of FIX.
               if (whi) hi_reg <= wdata;
               if (wlo) lo_reg <= wdata;
               if (start && !flush) begin
                  is_div_reg <= op[1];
                  neg_q_reg  <= sign_a ^ sign_b;
                  neg_r_reg  <= sign_a;
                  dz_reg     <= op[1] && (srcb == '0);
                  araw_reg   <= srca;
                  acc_reg    <= '0;
                  rem_reg    <= '0;
                  if (op[1]) begin
                     mplier_reg <= mag_a;
                     mcand_reg  <= {{WIDTH{1'b0}}, mag_b};
                  end else begin
                     mplier_reg <= mag_b;
                     mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
                  end
               end
            end
            CALC: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (is_div_reg) begin
                  rem_reg    <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  mplier_reg <= {mplier_reg[WIDTH-2:0], div_ok};
               end else begin
                  acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
                  mcand_reg  <= mcand_reg << 1;
                  mplier_reg <= mplier_reg >> 1;
               end
            end
            FIX: begin
               if (!flush) begin
                  hi_reg <= res_hi;
                  lo_reg <= res_lo;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_reg != IDLE);
   assign done        = (state_reg == DONE);
   assign div_by_zero = (state_reg == DONE) && dz_reg;
   assign hi          = hi_reg;
   assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  srca, srcb;
   logic          flush;
   logic          whi, wlo;
   logic [W-1:0]  wdata;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int pass_cnt  = 0;
   int total_cnt = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .srca(srca), .srcb(srcb), .flush(flush),
      .whi(whi), .wlo(wlo), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single cycle, then wait (bounded) for done.
   // Checks latency, busy, the result, div_by_zero and the one-cycle pulse.
   task automatic run_op(input string name, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_dz);
      int cyc;
      op = o; srca = a; srcb = b; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL %s busy: got %b want 1", name, busy);
      else pass_cnt++;
      while (done !== 1'b1 && cyc < 100) begin
         step();
         cyc++;
      end
      total_cnt++;
      if (cyc !== W + 2) $display("FAIL %s latency: got %0d want %0d", name, cyc, W + 2);
      else pass_cnt++;
      total_cnt++;
      if (hi !== exp_hi) $display("FAIL %s hi: got %h want %h", name, hi, exp_hi);
      else pass_cnt++;
      total_cnt++;
      if (lo !== exp_lo) $display("FAIL %s lo: got %h want %h", name, lo, exp_lo);
      else pass_cnt++;
      total_cnt++;
      if (div_by_zero !== exp_dz) $display("FAIL %s div_by_zero: got %b want %b", name, div_by_zero, exp_dz);
      else pass_cnt++;
      $display("op %s a=%h b=%h -> hi=%h lo=%h dz=%b cycles=%0d", name, a, b, hi, lo, div_by_zero, cyc);
      step();
      total_cnt++;
      if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0)
         $display("FAIL %s pulse: got done=%b dz=%b busy=%b want 0 0 0", name, done, div_by_zero, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
      flush = 1'b0; whi = 1'b0; wlo = 1'b0; wdata = '0;
      step(); step();
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0)
         $display("FAIL reset flags: got busy=%b done=%b dz=%b want 0 0 0", busy, done, div_by_zero);
      else pass_cnt++;
      total_cnt++;
      if (hi !== '0 || lo !== '0) $display("FAIL reset hilo: got %h %h want 0 0", hi, lo);
      else pass_cnt++;
      reset = 1'b0;
      step();
      $display("reset done");
   endtask

   task automatic test_mult();
      run_op("MULT_neg2x3",   2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      run_op("MULTU_maxsq",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_op("MULT_negxneg",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
   endtask

   task automatic test_div();
      run_op("DIV_m7d2",      2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("DIV_7dm2",      2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      run_op("DIVU_100d7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
      run_op("DIVU_5d0",      2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
      run_op("DIV_ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
   endtask

   task automatic test_mthi_mtlo();
      whi = 1'b1; wdata = 32'h00001234;
      step();
      whi = 1'b0;
      total_cnt++;
      if (hi !== 32'h00001234) $display("FAIL mthi_idle: got %h want 00001234", hi);
      else pass_cnt++;
      wlo = 1'b1; wdata = 32'h0000BEEF;
      step();
      wlo = 1'b0;
      total_cnt++;
      if (lo !== 32'h0000BEEF || hi !== 32'h00001234)
         $display("FAIL mtlo_idle: got hi=%h lo=%h want 00001234 0000beef", hi, lo);
      else pass_cnt++;
      whi = 1'b1; wlo = 1'b1; wdata = 32'hCAFE0001;
      step();
      whi = 1'b0; wlo = 1'b0;
      total_cnt++;
      if (hi !== 32'hCAFE0001 || lo !== 32'hCAFE0001)
         $display("FAIL mthilo_both: got hi=%h lo=%h want cafe0001 cafe0001", hi, lo);
      else pass_cnt++;
      $display("mthi/mtlo idle writes hi=%h lo=%h", hi, lo);
   endtask

   // Writes and a second start while busy are both ignored; exactly one done.
   task automatic test_busy_ignores();
      int dones;
      whi = 1'b1; wdata = 32'h00005555;
      step();
      whi = 1'b0;
      op = 2'b01; srca = 32'd3; srcb = 32'd5; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      whi = 1'b1; wdata = 32'h00001234;
      op = 2'b11; srca = 32'd100; srcb = 32'd7; start = 1'b1;
      step();
      whi = 1'b0; start = 1'b0;
      total_cnt++;
      if (hi !== 32'h00005555) $display("FAIL mthi_busy: got %h want 00005555", hi);
      else pass_cnt++;
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         if (done === 1'b1) begin
            dones++;
            total_cnt++;
            if (hi !== 32'd0 || lo !== 32'd15)
               $display("FAIL busy_start_result: got hi=%h lo=%h want 0 f", hi, lo);
            else pass_cnt++;
         end
         step();
      end
      total_cnt++;
      if (dones !== 1) $display("FAIL busy_start_dones: got %0d want 1", dones);
      else pass_cnt++;
      $display("busy-ignore op done count=%0d hi=%h lo=%h", dones, hi, lo);
   endtask

   // start with whi in the same IDLE cycle: write lands first, result overwrites.
   task automatic test_start_with_write();
      int cyc;
      op = 2'b01; srca = 32'd6; srcb = 32'd7; start = 1'b1;
      whi = 1'b1; wdata = 32'h0000ABCD;
      step();
      start = 1'b0; whi = 1'b0;
      total_cnt++;
      if (hi !== 32'h0000ABCD) $display("FAIL start_write_now: got %h want 0000abcd", hi);
      else pass_cnt++;
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         step();
         cyc++;
      end
      total_cnt++;
      if (hi !== 32'd0 || lo !== 32'd42 || done !== 1'b1)
         $display("FAIL start_write_result: got hi=%h lo=%h done=%b want 0 2a 1", hi, lo, done);
      else pass_cnt++;
      $display("start+whi op hi=%h lo=%h", hi, lo);
      step();
   endtask

   task automatic test_flush();
      int dones;
      whi = 1'b1; wlo = 1'b1; wdata = 32'h77770000;
      step();
      whi = 1'b0; wlo = 1'b0;
      op = 2'b00; srca = 32'd9; srcb = 32'd9; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 9; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy);
      else pass_cnt++;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) dones++;
         step();
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL flush_nodone: got %0d want 0", dones);
      else pass_cnt++;
      total_cnt++;
      if (hi !== 32'h77770000 || lo !== 32'h77770000)
         $display("FAIL flush_hilo: got hi=%h lo=%h want 77770000 77770000", hi, lo);
      else pass_cnt++;
      $display("flush in CALC hi=%h lo=%h dones=%0d", hi, lo, dones);
      // start together with flush in IDLE is dropped
      op = 2'b01; srca = 32'd2; srcb = 32'd2; start = 1'b1; flush = 1'b1;
      step();
      start = 1'b0; flush = 1'b0;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL flush_start_drop: got busy=%b want 0", busy);
      else pass_cnt++;
      $display("start with flush dropped busy=%b", busy);
      run_op("MULTU_after_flush", 2'b01, 32'd12, 32'd11, 32'd0, 32'd132, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_op("DIVU_b2b_1", 2'b11, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0);
      run_op("MULT_b2b_2", 2'b00, 32'hFFFFFFF0, 32'd16, 32'hFFFFFFFF, 32'hFFFFFF00, 1'b0);
   endtask

   task automatic test_reset_mid_op();
      int dones;
      op = 2'b01; srca = 32'd5; srcb = 32'd5; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || hi !== '0 || lo !== '0)
         $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
      else pass_cnt++;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) dones++;
         step();
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL reset_mid_nodone: got %0d want 0", dones);
      else pass_cnt++;
      $display("reset mid-op busy=%b dones=%0d", busy, dones);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_busy_ignores();
      test_start_with_write();
      test_flush();
      test_back_to_back();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
